// File: rtl/irsensor_pkg.sv
// Shared encodings and widths for the IR reflectance sensor scanner.
// Pure declarations: no logic, no latency, no flow control.
package irsensor_pkg;

    localparam int DECAY_W         = 16;
    localparam int COUNT_W         = 8;
    localparam int DEFAULT_TIMEOUT = 32768;

    typedef enum logic [2:0] {
        IDLE,
        CHARGE,
        MEASURE,
        STORE,
        NEXT
    } scan_state_t;

endpackage

// File: rtl/irsensor_edge_counter.sv
// Per-sensor black/white state plus white-to-black transition counter.
// Updates one cycle after update/clear; clear beats a simultaneous increment; never stalls.
module irsensor_edge_counter
    import irsensor_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               update,
    input  logic               new_black,
    input  logic               clear,
    output logic               black,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            black <= 1'b0;
            count <= '0;
        end else begin
            if (update) begin
                black <= new_black;
            end
            if (clear) begin
                count <= '0;
            end else if (update && new_black && !black) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/irsensor_scan_controller.sv
// Round-robin RC-decay scanner: charges, times and classifies one sensor at a time.
// Per-sensor period is CHARGE_CYCLES+decay+3 cycles; no backpressure, enable only gates the next sensor.
module irsensor_scan_controller
    import irsensor_pkg::*;
#(
    parameter int NUM_SENSORS   = 4,
    parameter int TIMEOUT       = DEFAULT_TIMEOUT,
    parameter int CHARGE_CYCLES = 500,
    parameter int THRESHOLD     = 2048,
    parameter int IDX_W         = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear_counts,
    input  logic [NUM_SENSORS-1:0] sensor_in,
    output logic [NUM_SENSORS-1:0] sensor_drive,
    output logic [NUM_SENSORS-1:0] sensor_oe,
    input  logic [IDX_W-1:0]       rd_sel,
    output logic [DECAY_W-1:0]     rd_decay,
    output logic [COUNT_W-1:0]     rd_count,
    output logic [NUM_SENSORS-1:0] black_mask,
    output logic                   scan_done,
    output logic                   busy
);

    localparam int                    CHG_W       = $clog2(CHARGE_CYCLES + 1);
    localparam logic [CHG_W-1:0]      CHARGE_LAST = CHG_W'(CHARGE_CYCLES - 1);
    localparam logic [DECAY_W:0]      TIMEOUT_V   = (DECAY_W + 1)'(TIMEOUT);
    localparam logic [DECAY_W:0]      THRESH_V    = (DECAY_W + 1)'(THRESHOLD);
    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_SENSORS - 1);
    localparam logic [NUM_SENSORS-1:0] ONE_HOT0   = NUM_SENSORS'(1);

    scan_state_t          state, state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [CHG_W-1:0]     charge_cnt;
    logic [DECAY_W-1:0]   decay_cnt;
    logic [DECAY_W:0]     decay_inc;
    logic                 store_en;
    logic                 new_black;
    logic [NUM_SENSORS-1:0] drive_mask;
    logic [DECAY_W-1:0]   decay_reg [NUM_SENSORS];
    logic [COUNT_W-1:0]   count_arr [NUM_SENSORS];

    assign decay_inc    = {1'b0, decay_cnt} + 1'b1;
    assign new_black    = {1'b0, decay_cnt} >= THRESH_V;
    assign sensor_drive = drive_mask;
    assign sensor_oe    = drive_mask;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        store_en   = 1'b0;
        scan_done  = 1'b0;
        drive_mask = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (enable) state_nxt = CHARGE;
            end
            CHARGE: begin
                drive_mask = ONE_HOT0 << idx;
                if (charge_cnt == CHARGE_LAST) state_nxt = MEASURE;
            end
            MEASURE: begin
                // a low node freezes the count; a still-charged node saturates at TIMEOUT
                if (!sensor_in[idx] || decay_inc >= TIMEOUT_V) state_nxt = STORE;
            end
            STORE: begin
                store_en  = 1'b1;
                state_nxt = NEXT;
            end
            NEXT: begin
                scan_done = (idx == LAST_IDX);
                state_nxt = enable ? CHARGE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            charge_cnt <= '0;
            decay_cnt  <= '0;
        end else begin
            case (state)
                CHARGE: begin
                    if (charge_cnt == CHARGE_LAST) begin
                        charge_cnt <= '0;
                        decay_cnt  <= '0;
                    end else begin
                        charge_cnt <= charge_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (sensor_in[idx]) decay_cnt <= decay_inc[DECAY_W-1:0];
                end
                NEXT: begin
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                default: charge_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SENSORS; i++) decay_reg[i] <= '0;
        end else if (store_en) begin
            decay_reg[idx] <= decay_cnt;
        end
    end

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_cnt
        irsensor_edge_counter u_cnt (
            .clock     (clock),
            .reset     (reset),
            .update    (store_en && (idx == IDX_W'(g))),
            .new_black (new_black),
            .clear     (clear_counts),
            .black     (black_mask[g]),
            .count     (count_arr[g])
        );
    end

    always_comb begin
        rd_decay = '0;
        rd_count = '0;
        if (32'(rd_sel) < NUM_SENSORS) begin
            rd_decay = decay_reg[rd_sel];
            rd_count = count_arr[rd_sel];
        end
    end

endmodule

// File: tb/tb_irsensor_scan_controller.sv
// Bench for the sensor scanner: an RC-decay sensor model reacts to oe and a scoreboard
// derives decay, colour and line count per measurement from the classification rules.
`timescale 1ns/1ps
module tb_irsensor_scan_controller;

    localparam int NS      = 4;
    localparam int TMO     = 100;
    localparam int CHG     = 8;
    localparam int THR     = 32;
    localparam int FOREVER = 65535;

    logic          clock        = 1'b0;
    logic          reset        = 1'b0;
    logic          enable       = 1'b0;
    logic          clear_counts = 1'b0;
    logic [NS-1:0] sensor_in    = '0;
    logic [1:0]    rd_sel       = '0;
    logic [NS-1:0] sensor_drive, sensor_oe, black_mask;
    logic [15:0]   rd_decay;
    logic [7:0]    rd_count;
    logic          scan_done, busy;

    int n_vec = 0;
    int n_err = 0;

    int cfg [NS]       = '{default: 0};
    int lat [NS]       = '{default: 0};
    int rem [NS]       = '{default: 0};
    bit charged [NS]   = '{default: 1'b0};
    int exp_decay [NS] = '{default: 0};
    int exp_count [NS] = '{default: 0};
    bit exp_black [NS] = '{default: 1'b0};
    int oe_run = 0, last_run = 0, viol_multi = 0, viol_len = 0;
    int scan_cnt = 0, s3_cnt = 0;

    irsensor_scan_controller #(
        .NUM_SENSORS(NS), .TIMEOUT(TMO), .CHARGE_CYCLES(CHG), .THRESHOLD(THR), .IDX_W(2)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear_counts(clear_counts),
        .sensor_in(sensor_in), .sensor_drive(sensor_drive), .sensor_oe(sensor_oe),
        .rd_sel(rd_sel), .rd_decay(rd_decay), .rd_count(rd_count),
        .black_mask(black_mask), .scan_done(scan_done), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic void record(input int i);
        int d;
        bit nb;
        d  = (lat[i] > TMO) ? TMO : lat[i];
        nb = (d >= THR);
        if (!exp_black[i] && nb) exp_count[i] = (exp_count[i] + 1) % 256;
        exp_black[i] = nb;
        exp_decay[i] = d;
        if (i == NS - 1) s3_cnt++;
    endfunction

    function automatic logic [NS-1:0] exp_mask();
        logic [NS-1:0] m;
        for (int i = 0; i < NS; i++) m[i] = exp_black[i];
        return m;
    endfunction

    // Sensor node: held high while driven, then stays high for cfg cycles after release.
    always @(negedge clock) begin
        int ones;
        ones = 0;
        for (int i = 0; i < NS; i++) begin
            if (sensor_oe[i]) begin
                ones++;
                rem[i] = cfg[i];
                lat[i] = cfg[i];
                charged[i] = 1'b1;
                sensor_in[i] = 1'b1;
            end else begin
                if (charged[i]) begin
                    record(i);
                    charged[i] = 1'b0;
                end
                sensor_in[i] = (rem[i] != 0);
                if (rem[i] > 0) rem[i]--;
            end
        end
        if (ones > 1 || sensor_oe !== sensor_drive) viol_multi++;
        if (sensor_oe != '0) oe_run++;
        else if (oe_run != 0) begin
            last_run = oe_run;
            if (oe_run != CHG) viol_len++;
            oe_run = 0;
        end
        if (scan_done === 1'b1) scan_cnt++;
    end

    task automatic wait_scans(input int n, input bit stop, output bit ok);
        int seen;
        seen = 0;
        ok   = 1'b0;
        for (int c = 0; c < 20000 && !ok; c++) begin
            @(negedge clock);
            if (scan_done === 1'b1) begin
                seen++;
                if (seen == n) begin
                    ok = 1'b1;
                    if (stop) enable = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_oe(input int i, input logic lvl, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 5000 && !ok; c++) begin
            @(negedge clock);
            if (sensor_oe[i] === lvl) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (scan_done !== 1'b0) begin n_err++; $display("FAIL reset_scan_done: got %b expected 0", scan_done); end
        n_vec++; if (sensor_oe !== 4'b0 || sensor_drive !== 4'b0) begin n_err++; $display("FAIL reset_oe: got oe=%b drive=%b expected 0", sensor_oe, sensor_drive); end
        n_vec++; if (black_mask !== 4'b0) begin n_err++; $display("FAIL reset_mask: got %b expected 0", black_mask); end
        for (int s = 0; s < NS; s++) begin
            rd_sel = 2'(s); #1;
            n_vec++; if (rd_decay !== 16'd0 || rd_count !== 8'd0) begin n_err++; $display("FAIL reset_rd[%0d]: got decay=%0d count=%0d expected 0", s, rd_decay, rd_count); end
        end
    endtask

    task automatic test_first_sensor();
        bit ok;
        cfg = '{20, 0, 0, 0};
        enable = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        wait_scans(1, 1'b1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL first_scan_timeout: got no scan_done expected one"); end
        @(negedge clock);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL first_idle: got busy=%b expected 0", busy); end
        n_vec++; if (last_run !== CHG || viol_len !== 0) begin n_err++; $display("FAIL first_oe_len: got %0d expected %0d", last_run, CHG); end
        n_vec++; if (black_mask[0] !== 1'b0) begin n_err++; $display("FAIL first_black: got %b expected 0", black_mask[0]); end
        for (int s = 0; s < NS; s++) begin
            rd_sel = 2'(s); #1;
            n_vec++; if (rd_decay !== 16'(s == 0 ? 20 : 0)) begin n_err++; $display("FAIL first_decay[%0d]: got %0d expected %0d", s, rd_decay, s == 0 ? 20 : 0); end
            n_vec++; if (rd_count !== 8'd0) begin n_err++; $display("FAIL first_count[%0d]: got %0d expected 0", s, rd_count); end
        end
    endtask

    task automatic test_timeout_counts();
        bit ok;
        int pat [4]     = '{FOREVER, FOREVER, 0, FOREVER};
        int cnt_exp [4] = '{1, 1, 1, 2};
        bit blk_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            cfg = '{0, pat[k], 0, 0};
            enable = 1'b1;
            wait_scans(1, 1'b1, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL timeout_scan%0d: got no scan_done expected one", k); end
            @(negedge clock);
            rd_sel = 2'd1; #1;
            n_vec++; if (rd_decay !== 16'(pat[k] == 0 ? 0 : TMO)) begin n_err++; $display("FAIL timeout_decay%0d: got %0d expected %0d", k, rd_decay, pat[k] == 0 ? 0 : TMO); end
            n_vec++; if (black_mask[1] !== blk_exp[k]) begin n_err++; $display("FAIL timeout_black%0d: got %b expected %b", k, black_mask[1], blk_exp[k]); end
            n_vec++; if (rd_count !== 8'(cnt_exp[k])) begin n_err++; $display("FAIL timeout_count%0d: got %0d expected %0d", k, rd_count, cnt_exp[k]); end
        end
    endtask

    task automatic test_four_sensors();
        bit ok;
        int sc0, s30;
        cfg = '{10, 50, 20, 80};
        sc0 = scan_cnt;
        s30 = s3_cnt;
        enable = 1'b1;
        wait_scans(3, 1'b1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL four_timeout: got no third scan_done"); end
        @(negedge clock);
        n_vec++; if (black_mask !== 4'b1010) begin n_err++; $display("FAIL four_mask: got %b expected 1010", black_mask); end
        n_vec++; if (scan_cnt - sc0 !== 3 || s3_cnt - s30 !== 3) begin n_err++; $display("FAIL four_scan_done: got %0d pulses for %0d sensor3 stores expected 3", scan_cnt - sc0, s3_cnt - s30); end
        n_vec++; if (viol_multi !== 0 || viol_len !== 0) begin n_err++; $display("FAIL four_oe: got %0d onehot and %0d length violations expected 0", viol_multi, viol_len); end
        for (int s = 0; s < NS; s++) begin
            rd_sel = 2'(s); #1;
            n_vec++; if (rd_decay !== 16'(exp_decay[s]) || rd_count !== 8'(exp_count[s])) begin n_err++; $display("FAIL four_rd[%0d]: got %0d/%0d expected %0d/%0d", s, rd_decay, rd_count, exp_decay[s], exp_count[s]); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        cfg = '{0, 0, 32, 0};
        @(negedge clock) clear_counts = 1'b1;
        @(negedge clock) clear_counts = 1'b0;
        for (int s = 0; s < NS; s++) exp_count[s] = 0;
        n_vec++; if (black_mask !== 4'b1010) begin n_err++; $display("FAIL clear_mask: got %b expected 1010", black_mask); end
        for (int s = 0; s < NS; s++) begin
            rd_sel = 2'(s); #1;
            n_vec++; if (rd_count !== 8'd0) begin n_err++; $display("FAIL clear_count[%0d]: got %0d expected 0", s, rd_count); end
        end
        enable = 1'b1;
        for (int k = 0; k < 512; k++) begin
            wait_scans(1, k == 511, ok);
            if (!ok) begin
                n_vec++; n_err++; $display("FAIL wrap_timeout: stalled at scan %0d", k);
                enable = 1'b0;
                break;
            end
            if (k == 508) begin
                rd_sel = 2'd2; #1;
                n_vec++; if (rd_count !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d expected 255", rd_count); end
            end
            cfg[2] = (k % 2 == 0) ? 0 : 32;
        end
        @(negedge clock);
        rd_sel = 2'd2; #1;
        n_vec++; if (rd_count !== 8'd0 || exp_count[2] !== 0) begin n_err++; $display("FAIL wrap_zero: got %0d expected 0", rd_count); end
    endtask

    task automatic test_clear_collision();
        bit ok1, ok2;
        cfg = '{0, 50, 0, 0};
        enable = 1'b1;
        wait_oe(1, 1'b1, ok1);
        wait_oe(1, 1'b0, ok2);
        n_vec++; if (!(ok1 && ok2)) begin n_err++; $display("FAIL collide_oe_timeout: sensor1 charge not seen"); end
        repeat (51) @(negedge clock);
        clear_counts = 1'b1;
        for (int s = 0; s < NS; s++) exp_count[s] = 0;
        @(negedge clock);
        clear_counts = 1'b0;
        rd_sel = 2'd1; #1;
        n_vec++; if (black_mask[1] !== 1'b1) begin n_err++; $display("FAIL collide_black: got %b expected 1", black_mask[1]); end
        n_vec++; if (rd_count !== 8'd0) begin n_err++; $display("FAIL collide_count: got %0d expected 0", rd_count); end
        wait_scans(1, 1'b1, ok1);
        n_vec++; if (!ok1) begin n_err++; $display("FAIL collide_scan_timeout: got no scan_done"); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int c;
        cfg = '{5, 10, 25, 40};
        enable = 1'b1;
        wait_oe(2, 1'b1, ok);
        enable = 1'b0;
        for (c = 0; c < 2000 && busy !== 1'b0; c++) @(negedge clock);
        n_vec++; if (!ok || busy !== 1'b0) begin n_err++; $display("FAIL drop_idle: got busy=%b expected 0", busy); end
        for (int s = 0; s < NS; s++) begin
            rd_sel = 2'(s); #1;
            n_vec++; if (rd_decay !== 16'(exp_decay[s])) begin n_err++; $display("FAIL drop_decay[%0d]: got %0d expected %0d", s, rd_decay, exp_decay[s]); end
        end
        n_vec++; if (exp_decay[2] !== 25) begin n_err++; $display("FAIL drop_stored: got %0d expected 25", exp_decay[2]); end
        enable = 1'b1;
        for (c = 0; c < 100 && sensor_oe === 4'b0; c++) @(negedge clock);
        n_vec++; if (sensor_oe !== 4'b1000) begin n_err++; $display("FAIL drop_resume: got %b expected 1000", sensor_oe); end
        wait_scans(1, 1'b1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL drop_scan_timeout: got no scan_done"); end
    endtask

    task automatic test_random_scans();
        bit ok;
        for (int s = 0; s < NS; s++) cfg[s] = $urandom_range(0, TMO + 20);
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_scans(1, k == 5, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL rand_timeout: scan %0d", k); end
            n_vec++; if (black_mask !== exp_mask()) begin n_err++; $display("FAIL rand_mask%0d: got %b expected %b", k, black_mask, exp_mask()); end
            for (int s = 0; s < NS; s++) begin
                rd_sel = 2'(s); #1;
                n_vec++; if (rd_decay !== 16'(exp_decay[s]) || rd_count !== 8'(exp_count[s])) begin n_err++; $display("FAIL rand_rd%0d[%0d]: got %0d/%0d expected %0d/%0d", k, s, rd_decay, rd_count, exp_decay[s], exp_count[s]); end
            end
            for (int s = 0; s < NS; s++) cfg[s] = $urandom_range(0, TMO + 20);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2;
        cfg = '{FOREVER, 0, 0, 0};
        enable = 1'b1;
        wait_oe(0, 1'b1, ok1);
        wait_oe(0, 1'b0, ok2);
        repeat (5) @(negedge clock);
        n_vec++; if (!(ok1 && ok2) || busy !== 1'b1) begin n_err++; $display("FAIL midreset_pre: got busy=%b expected 1", busy); end
        #2 reset = 1'b0;
        enable = 1'b0;
        #1;
        n_vec++; if (sensor_oe !== 4'b0 || sensor_drive !== 4'b0) begin n_err++; $display("FAIL midreset_oe: got %b/%b expected 0", sensor_oe, sensor_drive); end
        n_vec++; if (busy !== 1'b0 || scan_done !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b/%b expected 0", busy, scan_done); end
        n_vec++; if (black_mask !== 4'b0) begin n_err++; $display("FAIL midreset_mask: got %b expected 0", black_mask); end
        for (int s = 0; s < NS; s++) begin
            rd_sel = 2'(s); #1;
            n_vec++; if (rd_decay !== 16'd0 || rd_count !== 8'd0) begin n_err++; $display("FAIL midreset_rd[%0d]: got %0d/%0d expected 0", s, rd_decay, rd_count); end
        end
    endtask

    initial begin
        test_reset();
        test_first_sensor();
        test_timeout_counts();
        test_four_sensors();
        test_wrap();
        test_clear_collision();
        test_enable_drop();
        test_random_scans();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/irsensor_scan_controller.md
Name: irsensor_scan_controller

Overview:
Sequencer that time-multiplexes one RC-decay infrared measurement datapath across NUM_SENSORS reflectance sensors in round-robin order. For each sensor it charges the sensor node, releases it, and times the decay. It then classifies the sensor as black or white and updates that sensor's white-to-black transition counter. It sits between the sensor pins and the NIOS II register bank, and provides per-sensor decay time, black mask and line counts.

Parameters:
NUM_SENSORS, 4, number of sensors scanned (2..8)
TIMEOUT, 32768, maximum decay count per measurement (saturates, counts as black)
CHARGE_CYCLES, 500, clock cycles the sensor node is driven high before release
THRESHOLD, 2048, decay count at or above which a sensor reads black
IDX_W, 2, width of sensor index (clog2 NUM_SENSORS, min 1)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = run continuous scans; 0 = finish current sensor, then idle
clear_counts  input  1  synchronous pulse: zero all line counters
sensor_in  input  NUM_SENSORS  synchronised sensor node levels (1 = still charged)
sensor_drive  output  NUM_SENSORS  one-hot drive-high during CHARGE, else 0
sensor_oe  output  NUM_SENSORS  one-hot output enable during CHARGE, else 0 (node floats)
rd_sel  input  IDX_W  sensor selected for readback
rd_decay  output  16  last decay count of sensor rd_sel (saturated at TIMEOUT)
rd_count  output  8  line count of sensor rd_sel
black_mask  output  NUM_SENSORS  current black/white classification per sensor
scan_done  output  1  one-cycle pulse after the last sensor of a scan is stored
busy  output  1  1 whenever FSM is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, index=0, all decay regs=0, counts=0, black_mask=0, drive/oe=0, scan_done=0, busy=0, timers=0.
- FSM states: IDLE, CHARGE, MEASURE, STORE, NEXT.
- IDLE: enable=1 -> CHARGE for the current index and load the charge timer.
- CHARGE: sensor_oe[idx]=sensor_drive[idx]=1 for exactly CHARGE_CYCLES cycles. Then drop oe/drive and go to MEASURE with the decay counter at 0.
- MEASURE: the counter increments each cycle while sensor_in[idx]=1. It exits on the first cycle sensor_in[idx]=0 (count frozen) or when the count reaches TIMEOUT (count=TIMEOUT). It then goes to STORE.
- STORE (1 cycle): the decay reg[idx] takes min(count, TIMEOUT). The new black bit is (count >= THRESHOLD). black_mask[idx] updates. If the old bit=0 and the new bit=1, count[idx] increments mod 256 (255 wraps to 0).
- NEXT (1 cycle):
  - If idx=NUM_SENSORS-1, pulse scan_done and set idx=0; otherwise idx+1.
  - Then go to CHARGE if enable=1, else IDLE.
- enable deasserted mid-sensor: the current sensor completes through STORE/NEXT. No partial results are discarded.
- clear_counts: all counters go to 0 in the next cycle. If it coincides with a STORE increment, the clear wins (result 0). black_mask is not cleared.
- Readback is combinational from rd_sel. rd_sel >= NUM_SENSORS returns 0 on both fields.
- A sensor already low at the first MEASURE cycle stores decay=0 (white).
- Only one sensor is ever driven at a time. sensor_oe is never asserted outside CHARGE.
- Scan period per sensor = CHARGE_CYCLES + decay + 3 cycles (MEASURE exit, STORE, NEXT).

Decomposition:
- Package irsensor_pkg holds:
  - the FSM state encoding (IDLE..NEXT);
  - DECAY_W=16 and COUNT_W=8;
  - a helper constant for the default TIMEOUT.
- Sub-module irsensor_edge_counter is instantiated NUM_SENSORS times. Each instance holds a black bit and an 8-bit count, with inputs update, new_black and clear. The FSM and timers remain in the top level.

Test Plan:
- Reset release with enable=1, sensor_in[0] falls 100 cycles after release -> oe[0] high exactly 500 cycles, rd_decay(sel 0)=100, black_mask[0]=0, count[0]=0.
- Sensor 1 held high forever -> MEASURE exits at 32768, rd_decay=32768, black_mask[1]=1, count[1]=1. Repeat for the next scan -> count stays 1. Make it white, then black again -> count=2.
- Four sensors with decays 10/3000/20/5000 -> scan_done pulses once per scan after sensor 3 STORE, black_mask=4'b1010, only one oe bit ever high.
- Drive 256 white->black transitions on sensor 2 -> count wraps to 0. clear_counts in the same cycle as an increment -> count=0.
- enable dropped during CHARGE of sensor 2 -> sensor 2 completes and stores, idx=3, FSM IDLE, busy=0. Re-enable -> resumes at sensor 3.
- reset asserted mid-MEASURE -> oe/drive immediately 0, all outputs at reset values without waiting for a clock edge.
